// File: rtl/fp_div_iter_unit.sv
// Iterative radix-2 restoring integer divider (DIV/DIVU/REM/REMU).
// One quotient bit per cycle; fixed latency of WIDTH+2 cycles from accept to result.
module fp_div_iter_unit #(
    parameter int WIDTH           = 32,
    parameter int TAG_WIDTH       = 4,
    parameter int ALLOW_BACK2BACK = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 En_i,
    input  logic [1:0]           Op_i,
    input  logic [WIDTH-1:0]     OpA_i,
    input  logic [WIDTH-1:0]     OpB_i,
    input  logic [TAG_WIDTH-1:0] Tag_i,
    output logic                 Ready_o,
    output logic                 Valid_o,
    input  logic                 ResReady_i,
    output logic [WIDTH-1:0]     Res_o,
    output logic [TAG_WIDTH-1:0] Tag_o,
    output logic [1:0]           Status_o
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIXUP, S_DONE} state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [1:0]            op_q, op_d;
    logic [WIDTH-1:0]      opa_q, opa_d, opb_q, opb_d;
    logic [WIDTH-1:0]      dvd_q, dvd_d;      // dividend in, quotient out (shifted MSB first)
    logic [WIDTH-1:0]      dvs_q, dvs_d;      // divisor magnitude
    logic [WIDTH:0]        rem_q, rem_d;      // partial remainder
    logic                  qneg_q, qneg_d, rneg_q, rneg_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d, tag_out_q, tag_out_d;
    logic [WIDTH-1:0]      res_q, res_d;
    logic [1:0]            status_q, status_d;

    logic                  accept;
    logic                  is_signed, is_rem, div0, ovf;
    logic [WIDTH+1:0]      trial, diff;
    logic [WIDTH-1:0]      q_fix, r_fix;

    assign accept    = En_i & Ready_o;
    assign is_signed = ~op_q[0];
    assign is_rem    = op_q[1];
    assign div0      = (opb_q == '0);
    assign ovf       = is_signed & (opa_q == MOST_NEG) & (&opb_q);

    // Restoring step: shift next dividend bit into the remainder and try subtracting.
    assign trial = {rem_q, dvd_q[WIDTH-1]};
    assign diff  = trial - {2'b00, dvs_q};

    // Sign fixup of the raw magnitudes.
    assign q_fix = qneg_q ? (~dvd_q + 1'b1) : dvd_q;
    assign r_fix = rneg_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_PREP;
            S_PREP:  state_d = S_ITER;
            S_ITER:  if (cnt_q == CW'(WIDTH-1)) state_d = S_FIXUP;
            S_FIXUP: state_d = S_DONE;
            S_DONE:  if (ResReady_i) state_d = accept ? S_PREP : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        Ready_o = (state_q == S_IDLE) |
                  ((ALLOW_BACK2BACK != 0) & (state_q == S_DONE) & ResReady_i);
        Valid_o = (state_q == S_DONE);
    end

    // Datapath next values: capture, prepare magnitudes, iterate, fix up
    always_comb begin
        cnt_d     = cnt_q;
        op_d      = op_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        tag_d     = tag_q;
        tag_out_d = tag_out_q;
        res_d     = res_q;
        status_d  = status_q;

        if (accept) begin
            op_d  = Op_i;
            opa_d = OpA_i;
            opb_d = OpB_i;
            tag_d = Tag_i;
        end

        case (state_q)
            S_PREP: begin
                dvd_d  = (is_signed & opa_q[WIDTH-1]) ? (~opa_q + 1'b1) : opa_q;
                dvs_d  = (is_signed & opb_q[WIDTH-1]) ? (~opb_q + 1'b1) : opb_q;
                rem_d  = '0;
                cnt_d  = '0;
                qneg_d = is_signed & (opa_q[WIDTH-1] ^ opb_q[WIDTH-1]);
                rneg_d = is_signed & opa_q[WIDTH-1];
            end
            S_ITER: begin
                // No borrow means the divisor fits: keep the difference, quotient bit 1.
                if (!diff[WIDTH+1]) begin
                    rem_d = diff[WIDTH:0];
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = trial[WIDTH:0];
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = (cnt_q == CW'(WIDTH-1)) ? '0 : cnt_q + CW'(1);
            end
            S_FIXUP: begin
                tag_out_d = tag_q;
                if (div0) begin
                    res_d    = is_rem ? opa_q : '1;
                    status_d = 2'b01;
                end else if (ovf) begin
                    res_d    = is_rem ? '0 : MOST_NEG;
                    status_d = 2'b10;
                end else begin
                    res_d    = is_rem ? r_fix : q_fix;
                    status_d = 2'b00;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            op_q      <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            tag_q     <= '0;
            tag_out_q <= '0;
            res_q     <= '0;
            status_q  <= 2'b00;
        end else begin
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            tag_q     <= tag_d;
            tag_out_q <= tag_out_d;
            res_q     <= res_d;
            status_q  <= status_d;
        end
    end

    assign Res_o    = res_q;
    assign Tag_o    = tag_out_q;
    assign Status_o = status_q;

endmodule

// File: tb/tb_fp_div_iter_unit.sv
// Self-checking bench for fp_div_iter_unit at WIDTH=32 against an arithmetic reference model.
module tb_fp_div_iter_unit;
    localparam int W  = 32;
    localparam int TW = 4;
    localparam int LAT = W + 2;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          En_i = 1'b0;
    logic [1:0]    Op_i = 2'b00;
    logic [W-1:0]  OpA_i = '0;
    logic [W-1:0]  OpB_i = '0;
    logic [TW-1:0] Tag_i = '0;
    logic          Ready_o, Valid_o;
    logic          ResReady_i = 1'b0;
    logic [W-1:0]  Res_o;
    logic [TW-1:0] Tag_o;
    logic [1:0]    Status_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    fp_div_iter_unit #(.WIDTH(W), .TAG_WIDTH(TW), .ALLOW_BACK2BACK(1)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .En_i(En_i), .Op_i(Op_i),
        .OpA_i(OpA_i), .OpB_i(OpB_i), .Tag_i(Tag_i), .Ready_o(Ready_o),
        .Valid_o(Valid_o), .ResReady_i(ResReady_i), .Res_o(Res_o),
        .Tag_o(Tag_o), .Status_o(Status_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference: plain 64-bit arithmetic with the special cases from the rules.
    function automatic void ref_model(input logic [1:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b,
                                      output logic [W-1:0] r, output logic [1:0] st);
        longint sa, sb, ua, ub, v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        if (b == 0) begin
            r  = op[1] ? a : {W{1'b1}};
            st = 2'b01;
        end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r  = op[1] ? 32'h0 : 32'h8000_0000;
            st = 2'b10;
        end else begin
            case (op)
                2'b00:   v = sa / sb;
                2'b01:   v = ua / ub;
                2'b10:   v = sa % sb;
                default: v = ua % ub;
            endcase
            r  = v[W-1:0];
            st = 2'b00;
        end
    endfunction

    // Present a request at a negedge, let one rising edge pass, then drop En/ResReady.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [TW-1:0] tag, input logic rr);
        En_i = 1'b1; Op_i = op; OpA_i = a; OpB_i = b; Tag_i = tag; ResReady_i = rr;
        @(posedge clk_i);
        @(negedge clk_i);
        En_i = 1'b0; ResReady_i = 1'b0;
    endtask

    // Count falling edges since the accepting edge until Valid_o (bounded).
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!Valid_o && lat < 100) begin
            @(negedge clk_i);
            lat++;
        end
    endtask

    task automatic consume();
        ResReady_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        ResReady_i = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total_cnt++;
        if ({Valid_o, Res_o, Tag_o, Status_o} !== '0) begin
            $display("FAIL reset_outputs: got valid=%b res=%h tag=%h st=%b required all zero",
                     Valid_o, Res_o, Tag_o, Status_o);
        end else pass_cnt++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        total_cnt++;
        if (Ready_o !== 1'b1) $display("FAIL reset_ready: got %b required 1", Ready_o);
        else pass_cnt++;
    endtask

    task automatic test_directed();
        logic [1:0]   ops [7]  = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01};
        logic [W-1:0] as  [7]  = '{32'd100, 32'd100, -32'sd7, -32'sd7, 32'd7, 32'h8000_0000, 32'd5};
        logic [W-1:0] bs  [7]  = '{32'd7, 32'd7, 32'd2, 32'd2, -32'sd2, 32'hFFFF_FFFF, 32'd0};
        logic [W-1:0] ers [7]  = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1,
                                   32'h8000_0000, 32'hFFFF_FFFF};
        logic [1:0]   ests[7]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01};
        int lat;
        for (int i = 0; i < 7; i++) begin
            issue(ops[i], as[i], bs[i], TW'(5 + i), 1'b0);
            wait_valid(lat);
            total_cnt++;
            if (lat !== LAT) $display("FAIL dir%0d_latency: got %0d required %0d", i, lat, LAT);
            else pass_cnt++;
            total_cnt++;
            if ({Res_o, Tag_o, Status_o} !== {ers[i], TW'(5 + i), ests[i]})
                $display("FAIL dir%0d_result: got res=%h tag=%0d st=%b required res=%h tag=%0d st=%b",
                         i, Res_o, Tag_o, Status_o, ers[i], 5 + i, ests[i]);
            else pass_cnt++;
            consume();
        end
        // REM 5/0 returns the dividend
        issue(2'b10, 32'd5, 32'd0, 4'd2, 1'b0);
        wait_valid(lat);
        total_cnt++;
        if ({Res_o, Status_o} !== {32'd5, 2'b01})
            $display("FAIL rem_div0: got res=%h st=%b required res=5 st=01", Res_o, Status_o);
        else pass_cnt++;
        consume();
    endtask

    task automatic test_random();
        logic [1:0]   op;
        logic [W-1:0] a, b, er;
        logic [1:0]   est;
        logic [TW-1:0] tg;
        int lat;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 20)) * (($urandom_range(0, 1) != 0) ? -1 : 1);
                3: a = 32'($urandom_range(0, 1000));
                default: ;
            endcase
            tg = 4'($urandom);
            ref_model(op, a, b, er, est);
            issue(op, a, b, tg, 1'b0);
            wait_valid(lat);
            total_cnt++;
            if (lat !== LAT || {Res_o, Tag_o, Status_o} !== {er, tg, est})
                $display("FAIL rand%0d op=%b a=%h b=%h: got lat=%0d res=%h tag=%h st=%b required lat=%0d res=%h tag=%h st=%b",
                         i, op, a, b, lat, Res_o, Tag_o, Status_o, LAT, er, tg, est);
            else pass_cnt++;
            consume();
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] er;
        logic [1:0]   est;
        logic [W-1:0] r0;
        logic [TW-1:0] t0;
        logic [1:0]   s0;
        int lat;
        issue(2'b01, 32'd1000, 32'd3, 4'd7, 1'b0);
        wait_valid(lat);
        r0 = Res_o; t0 = Tag_o; s0 = Status_o;
        total_cnt++;
        if (r0 !== 32'd333) $display("FAIL bp_result: got %h required %h", r0, 32'd333);
        else pass_cnt++;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            total_cnt++;
            if ({Valid_o, Ready_o, Res_o, Tag_o, Status_o} !== {2'b10, r0, t0, s0})
                $display("FAIL bp_hold%0d: got v=%b rdy=%b res=%h tag=%h st=%b required v=1 rdy=0 res=%h tag=%h st=%b",
                         c, Valid_o, Ready_o, Res_o, Tag_o, Status_o, r0, t0, s0);
            else pass_cnt++;
        end
        // Consume and issue in the same cycle
        ResReady_i = 1'b1; En_i = 1'b1;
        #1;
        total_cnt++;
        if (Ready_o !== 1'b1) $display("FAIL b2b_ready: got %b required 1", Ready_o);
        else pass_cnt++;
        ref_model(2'b00, -32'sd100, 32'd9, er, est);
        issue(2'b00, -32'sd100, 32'd9, 4'd12, 1'b1);
        wait_valid(lat);
        total_cnt++;
        if (lat !== LAT || {Res_o, Tag_o, Status_o} !== {er, 4'd12, est})
            $display("FAIL b2b_result: got lat=%0d res=%h tag=%0d st=%b required lat=%0d res=%h tag=12 st=%b",
                     lat, Res_o, Tag_o, Status_o, LAT, er, est);
        else pass_cnt++;
        consume();
    endtask

    task automatic test_ignore_en();
        int lat;
        issue(2'b01, 32'd1000, 32'd10, 4'd3, 1'b0);
        repeat (10) @(negedge clk_i);
        En_i = 1'b1; Op_i = 2'b11; OpA_i = 32'd55; OpB_i = 32'd4; Tag_i = 4'd9;
        @(negedge clk_i);
        En_i = 1'b0;
        wait_valid(lat);
        total_cnt++;
        if (lat + 11 !== LAT || {Res_o, Tag_o, Status_o} !== {32'd100, 4'd3, 2'b00})
            $display("FAIL ignore_en: got lat=%0d res=%h tag=%0d st=%b required lat=%0d res=64 tag=3 st=00",
                     lat + 11, Res_o, Tag_o, Status_o, LAT);
        else pass_cnt++;
        consume();
    endtask

    task automatic test_reset_mid();
        int vcount;
        issue(2'b00, 32'd77, 32'd5, 4'd6, 1'b0);
        repeat (10) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        total_cnt++;
        if ({Valid_o, Res_o, Tag_o, Status_o} !== '0)
            $display("FAIL reset_mid_outputs: got v=%b res=%h tag=%h st=%b required all zero",
                     Valid_o, Res_o, Tag_o, Status_o);
        else pass_cnt++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        total_cnt++;
        if (Ready_o !== 1'b1) $display("FAIL reset_mid_ready: got %b required 1", Ready_o);
        else pass_cnt++;
        vcount = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (Valid_o) vcount++;
        end
        total_cnt++;
        if (vcount !== 0) $display("FAIL reset_mid_spurious: got %0d valid cycles required 0", vcount);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_ignore_en();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no completion required finish");
        $fatal(1);
    end
endmodule
